// File: rtl/mem32_seq.sv
// Sequences 32-bit or single-byte stores/fetches onto an 8-bit synchronous single-port RAM,
// one byte per cycle, little-endian, with registered RAM-side outputs.
module mem32_seq #(
  parameter int unsigned ASZ = 17,
  parameter int unsigned DSZ = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req,
  input  logic           wr,
  input  logic           bsz,
  input  logic [ASZ-1:0] addr,
  input  logic [31:0]    wdata,
  output logic [31:0]    rdata,
  output logic           busy,
  output logic           done,
  output logic           mem_we,
  output logic [ASZ-1:0] mem_ai,
  output logic [DSZ-1:0] mem_vi,
  input  logic [DSZ-1:0] mem_vo
);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StDone} state_e;

  state_e         state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic           bsz_q, bsz_d;
  logic [ASZ-1:0] addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           mem_we_q, mem_we_d;
  logic [ASZ-1:0] mem_ai_q, mem_ai_d;
  logic [DSZ-1:0] mem_vi_q, mem_vi_d;

  logic [2:0]     nbeats;
  logic [ASZ-1:0] beat_addr;
  logic [1:0]     cap_idx;

  assign nbeats    = bsz_q ? 3'd1 : 3'd4;
  assign beat_addr = addr_q + ASZ'(cnt_q);
  // RAM data for the address issued at count c arrives two counts later.
  assign cap_idx   = cnt_q[1:0] - 2'd2;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bsz_d    = bsz_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    mem_we_d = 1'b0;
    mem_ai_d = mem_ai_q;
    mem_vi_d = '0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          bsz_d   = bsz;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = 3'd0;
          if (wr) begin
            state_d = StWrite;
          end else begin
            state_d = StRead;
            rdata_d = '0;
          end
        end
      end
      StWrite: begin
        if (cnt_q < nbeats) begin
          mem_we_d = 1'b1;
          mem_ai_d = beat_addr;
          mem_vi_d = DSZ'(wdata_q >> {cnt_q[1:0], 3'b000});
          cnt_d    = cnt_q + 3'd1;
        end else begin
          state_d = StDone;
        end
      end
      StRead: begin
        if (cnt_q < nbeats) begin
          mem_ai_d = beat_addr;
        end
        if (cnt_q >= 3'd2) begin
          rdata_d[{cap_idx, 3'b000} +: 8] = 8'(mem_vo);
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == nbeats + 3'd1) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bsz_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      mem_we_q <= 1'b0;
      mem_ai_q <= '0;
      mem_vi_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bsz_q    <= bsz_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      mem_we_q <= mem_we_d;
      mem_ai_q <= mem_ai_d;
      mem_vi_q <= mem_vi_d;
    end
  end

  assign rdata  = rdata_q;
  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign mem_we = mem_we_q;
  assign mem_ai = mem_ai_q;
  assign mem_vi = mem_vi_q;

endmodule

// File: tb/tb_mem32_seq.sv
// Bench for mem32_seq: behavioural RAM, byte-array reference model, directed plus random ops.
module tb_mem32_seq;
  localparam int ASZ = 17;
  localparam int MSZ = 1 << ASZ;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req, wr, bsz;
  logic [ASZ-1:0] addr;
  logic [31:0]    wdata, rdata;
  logic           busy, done, mem_we;
  logic [ASZ-1:0] mem_ai;
  logic [7:0]     mem_vi, mem_vo;

  mem32_seq #(.ASZ(ASZ), .DSZ(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .bsz(bsz), .addr(addr), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done), .mem_we(mem_we), .mem_ai(mem_ai),
    .mem_vi(mem_vi), .mem_vo(mem_vo)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:MSZ-1];
  always @(posedge clk) begin
    if (mem_we) ram[mem_ai] <= mem_vi;
    mem_vo <= ram[mem_ai];
  end

  logic [7:0]  ref_mem [0:MSZ-1];
  logic [31:0] model_rd;
  int total = 0, bad = 0;
  int accepts = 0, dones = 0, we_in_read = 0;
  logic prev_busy = 1'b0, mon_rd = 1'b0;

  always @(negedge clk) begin
    if (busy && !prev_busy) accepts++;
    if (done) dones++;
    if (mon_rd && mem_we) we_in_read++;
    prev_busy = busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_fetch(input logic b, input logic [ASZ-1:0] a);
    logic [31:0] r = '0;
    for (int k = 0; k < (b ? 1 : 4); k++) r[8*k +: 8] = ref_mem[a + ASZ'(k)];
    return r;
  endfunction

  task automatic model_store(input logic b, input logic [ASZ-1:0] a, input logic [31:0] d);
    for (int k = 0; k < (b ? 1 : 4); k++) ref_mem[a + ASZ'(k)] = d[8*k +: 8];
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic do_op(input logic w, input logic b, input logic [ASZ-1:0] a,
                       input logic [31:0] d, input logic keep);
    int lat, cyc;
    lat = w ? (b ? 2 : 5) : (b ? 3 : 6);
    if (!w) model_rd = model_fetch(b, a);
    wr = w; bsz = b; addr = a; wdata = d; req = 1'b1; mon_rd = !w;
    @(posedge clk); #1;
    req = keep;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk(w ? "store_latency" : "fetch_latency", cyc, lat);
    chk("busy_with_done", {31'd0, busy}, 32'd1);
    if (!w) chk("rdata_on_done", rdata, model_rd);
    @(posedge clk); #1;
    chk("idle_after_done", {30'd0, busy, done}, 32'd0);
    chk("rdata_held", rdata, model_rd);
    @(negedge clk);
    mon_rd = 1'b0;
    if (w) model_store(b, a, d);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk(tag, {rdata[31:1] | {30'd0, busy}, rdata[0] | done}, 32'd0);
    chk(tag, {14'd0, mem_we, mem_ai}, 32'd0);
    chk(tag, {24'd0, mem_vi}, 32'd0);
  endtask

  initial begin
    int d0, n0;
    logic [ASZ-1:0] ra;
    model_rd = '0;
    rst_n = 1'b0; req = 1'b0; wr = 1'b0; bsz = 1'b0; addr = '0; wdata = '0;
    #3;
    chk_outputs_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    // Accepted on the first rising edge after reset release.
    do_op(1'b1, 1'b0, 17'h00010, 32'h44332211, 1'b0);
    chk("ram_10_13", {ram[17'h13], ram[17'h12], ram[17'h11], ram[17'h10]}, 32'h44332211);
    do_op(1'b0, 1'b0, 17'h00010, 32'h0, 1'b0);
    chk("cell_fetch_10", rdata, 32'h44332211);
    do_op(1'b0, 1'b1, 17'h00012, 32'h0, 1'b0);
    chk("byte_fetch_12", rdata, 32'h00000033);
    do_op(1'b1, 1'b0, 17'h00010, 32'hDEADBEEF, 1'b0);
    chk("store_keeps_rdata", rdata, 32'h00000033);

    // Byte store touches one location only.
    do_op(1'b1, 1'b1, 17'h00004, 32'h000000AA, 1'b0);
    do_op(1'b1, 1'b1, 17'h00006, 32'h000000BB, 1'b0);
    do_op(1'b1, 1'b1, 17'h00005, 32'hFFFFFF7E, 1'b0);
    chk("byte_store_neigh", {8'd0, ram[17'h6], ram[17'h5], ram[17'h4]}, 32'h00BB7EAA);

    // Address wrap.
    do_op(1'b1, 1'b0, 17'h1FFFF, 32'hA1B2C3D4, 1'b0);
    chk("wrap_ram", {ram[17'h2], ram[17'h1], ram[17'h0], ram[17'h1FFFF]}, 32'hA1B2C3D4);
    do_op(1'b0, 1'b0, 17'h1FFFF, 32'h0, 1'b0);
    chk("wrap_fetch", rdata, 32'hA1B2C3D4);

    // Random traffic over a pre-filled window.
    for (int i = 0; i < 8; i++) do_op(1'b1, 1'b0, 17'h200 + ASZ'(4 * i), $urandom, 1'b0);
    for (int i = 0; i < 30; i++) begin
      ra = 17'h200 + ASZ'($urandom_range(0, 28));
      do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, $urandom, 1'b0);
    end

    // req held high with alternating store/fetch.
    n0 = accepts; d0 = dones; we_in_read = 0;
    for (int i = 0; i < 6; i++)
      do_op((i % 2) == 0, 1'b0, 17'h00300, 32'hC0DE0000 + i, 1'b1);
    req = 1'b0;
    repeat (3) @(negedge clk);
    chk("accepts_req_high", accepts - n0, 6);
    chk("dones_req_high", dones - d0, 6);
    chk("we_during_read", we_in_read, 0);

    // Reset on the second write beat of a cell store.
    do_op(1'b1, 1'b0, 17'h00100, 32'h5A5A5A5A, 1'b0);
    wr = 1'b1; bsz = 1'b0; addr = 17'h00100; wdata = 32'h0F0E0D0C; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    d0 = dones;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("reset_mid_write");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("no_done_after_abort", dones - d0, 0);
    ref_mem[17'h100] = 8'h0C;
    model_rd = '0;
    chk("abort_ram", {ram[17'h103], ram[17'h102], ram[17'h101], ram[17'h100]}, 32'h5A5A5A0C);

    // Reset in the middle of a fetch discards partial data.
    wr = 1'b0; bsz = 1'b0; addr = 17'h00010; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_read_rdata", rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1'b0, 1'b0, 17'h00100, 32'h0, 1'b0);
    do_op(1'b0, 1'b1, 17'h00005, 32'h0, 1'b0);
    chk("byte_fetch_zero_ext", rdata, 32'h0000007E);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
